// File: rtl/cpu_control_sequencer.sv
// rtl/cpu_control_sequencer.sv - multi-cycle fetch/decode/execute/mem/writeback sequencer for the 16-bit CPU
// Strobes are decoded combinationally from the registered state; no extra output registers.
module cpu_control_sequencer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Run,
  input  logic [15:0]      IR,
  input  logic             Dec_WR,
  input  logic             Dec_MemWrite,
  input  logic [1:0]       Dec_PS,
  input  logic             MemAck,
  output logic             MemReq,
  output logic             AddrSel,
  output logic             MemWrite,
  output logic             IR_L,
  output logic             WR,
  output logic [1:0]       PS,
  output logic [2:0]       State,
  output logic             Busy,
  output logic             Err,
  output logic [CNT_W-1:0] Retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             is_halt, is_load, is_store, done;

  assign is_halt  = (IR == 16'hFFFF);
  assign is_load  = (IR[15:14] == 2'b01);
  assign is_store = (IR[15:14] == 2'b10);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      wait_q    <= 8'd0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    retired_d = retired_q;
    MemReq    = 1'b0;
    AddrSel   = 1'b0;
    MemWrite  = 1'b0;
    IR_L      = 1'b0;
    WR        = 1'b0;
    PS        = 2'b00;
    done      = 1'b0;
    case (state_q)
      S_IDLE: if (Run) state_d = S_FETCH;
      S_FETCH: begin
        MemReq = 1'b1;
        if (MemAck) begin
          IR_L    = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        if (is_halt)                  state_d = S_HALT;
        else if (is_load || is_store) state_d = S_MEM;
        else                          state_d = S_EXEC;
      end
      S_EXEC: begin
        WR   = Dec_WR;
        PS   = Dec_PS;
        done = 1'b1;
      end
      S_MEM: begin
        MemReq   = 1'b1;
        AddrSel  = 1'b1;
        MemWrite = is_store & Dec_MemWrite;
        if (MemAck) begin
          // Stores retire on the ack; loads still need the writeback phase.
          if (is_store) begin
            PS   = Dec_PS;
            done = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        WR   = Dec_WR;
        PS   = Dec_PS;
        done = 1'b1;
      end
      S_HALT: if (!Run) state_d = S_IDLE;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
    if (done) begin
      retired_d = retired_q + CNT_W'(1);
      state_d   = Run ? S_FETCH : S_IDLE;
    end
    // Any state change starts a fresh ack-wait window.
    if (state_d != state_q) wait_d = 8'd0;
  end

  assign State   = state_q;
  assign Busy    = (state_q inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB});
  assign Err     = (state_q == S_ERR);
  assign Retired = retired_q;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// tb/tb_cpu_control_sequencer.sv - scoreboard bench for cpu_control_sequencer
// Stimulus queues per-cycle expected outputs; a negedge monitor pops and compares.
module tb_cpu_control_sequencer;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Run = 1'b0;
  logic [15:0] IR = 16'h0000;
  logic        Dec_WR = 1'b0;
  logic        Dec_MemWrite = 1'b0;
  logic [1:0]  Dec_PS = 2'b00;
  logic        MemAck = 1'b0;
  logic        MemReq, AddrSel, MemWrite, IR_L, WR, Busy, Err;
  logic [1:0]  PS;
  logic [2:0]  State;
  logic [15:0] Retired;

  cpu_control_sequencer #(.TIMEOUT(15), .CNT_W(16)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Run(Run), .IR(IR),
    .Dec_WR(Dec_WR), .Dec_MemWrite(Dec_MemWrite), .Dec_PS(Dec_PS),
    .MemAck(MemAck), .MemReq(MemReq), .AddrSel(AddrSel),
    .MemWrite(MemWrite), .IR_L(IR_L), .WR(WR), .PS(PS),
    .State(State), .Busy(Busy), .Err(Err), .Retired(Retired)
  );

  always #5 Clock = ~Clock;

  // sig = {MemReq, AddrSel, MemWrite, IR_L, WR}
  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] FREQ = 5'b10000;
  localparam logic [4:0] FACK = 5'b10010;
  localparam logic [4:0] MREQ = 5'b11000;
  localparam logic [4:0] MST  = 5'b11100;
  localparam logic [4:0] WRS  = 5'b00001;

  typedef struct packed {
    logic [27:0] v;
    logic [15:0] id;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          n_pushed = 0;
  logic [15:0] ir_s = 16'h0;
  logic        dwr_s = 1'b0, dmw_s = 1'b0;
  logic [1:0]  dps_s = 2'b00;

  task automatic step(input logic rn, input logic run, input logic ack,
                      input logic [2:0] st, input logic [4:0] sig,
                      input logic [1:0] ps, input logic [15:0] ret);
    exp_t e;
    logic busy;
    @(posedge Clock);
    #1;
    Reset_n = rn; Run = run; MemAck = ack;
    IR = ir_s; Dec_WR = dwr_s; Dec_MemWrite = dmw_s; Dec_PS = dps_s;
    busy = (st >= 3'd1) && (st <= 3'd5);
    e.v  = {st, sig, ps, busy, (st == 3'd7), ret};
    e.id = 16'(n_pushed);
    n_pushed++;
    exp_q.push_back(e);
  endtask

  always @(negedge Clock) begin
    if (exp_q.size() > 0) begin
      exp_t        e;
      logic [27:0] act;
      e   = exp_q.pop_front();
      act = {State, MemReq, AddrSel, MemWrite, IR_L, WR, PS, Busy, Err, Retired};
      n_vec++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL vec%0d: got st=%0d sig=%b ps=%b busy=%b err=%b ret=%0d, want st=%0d sig=%b ps=%b busy=%b err=%b ret=%0d",
                 e.id, act[27:25], act[24:20], act[19:18], act[17], act[16], act[15:0],
                 e.v[27:25], e.v[24:20], e.v[19:18], e.v[17], e.v[16], e.v[15:0]);
      end
    end
  end

  initial begin
    // reset
    step(0, 0, 0, 3'd0, NONE, 2'b00, 16'd0);
    // ALU, ack on 2nd fetch cycle
    ir_s = 16'h0A5B; dwr_s = 1; dmw_s = 0; dps_s = 2'b01;
    step(1, 1, 0, 3'd0, NONE, 2'b00, 16'd0);
    step(1, 1, 0, 3'd1, FREQ, 2'b00, 16'd0);
    step(1, 1, 1, 3'd1, FACK, 2'b00, 16'd0);
    step(1, 1, 0, 3'd2, NONE, 2'b00, 16'd0);
    step(1, 1, 0, 3'd3, WRS,  2'b01, 16'd0);
    // load, ack delayed three MEM cycles
    ir_s = 16'h4123; dwr_s = 1; dmw_s = 0; dps_s = 2'b10;
    step(1, 1, 0, 3'd1, FREQ, 2'b00, 16'd1);
    step(1, 1, 1, 3'd1, FACK, 2'b00, 16'd1);
    step(1, 1, 0, 3'd2, NONE, 2'b00, 16'd1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 3'd4, MREQ, 2'b00, 16'd1);
    step(1, 1, 1, 3'd4, MREQ, 2'b00, 16'd1);
    step(1, 1, 0, 3'd5, WRS,  2'b10, 16'd1);
    // store, immediate ack, Run low so it returns to IDLE
    ir_s = 16'h8123; dwr_s = 1; dmw_s = 1; dps_s = 2'b11;
    step(1, 1, 1, 3'd1, FACK, 2'b00, 16'd2);
    step(1, 1, 0, 3'd2, NONE, 2'b00, 16'd2);
    step(1, 0, 1, 3'd4, MST,  2'b11, 16'd2);
    step(1, 0, 0, 3'd0, NONE, 2'b00, 16'd3);
    // halt
    ir_s = 16'hFFFF; dwr_s = 1; dmw_s = 1; dps_s = 2'b01;
    step(1, 1, 0, 3'd0, NONE, 2'b00, 16'd3);
    step(1, 1, 1, 3'd1, FACK, 2'b00, 16'd3);
    step(1, 1, 1, 3'd2, NONE, 2'b00, 16'd3);
    step(1, 1, 1, 3'd6, NONE, 2'b00, 16'd3);
    step(1, 0, 0, 3'd6, NONE, 2'b00, 16'd3);
    step(1, 1, 0, 3'd0, NONE, 2'b00, 16'd3);
    // fetch timeout after 15 cycles, sticky through Run toggling
    for (int i = 0; i < 15; i++) step(1, 1, 0, 3'd1, FREQ, 2'b00, 16'd3);
    step(1, 0, 1, 3'd7, NONE, 2'b00, 16'd3);
    step(1, 1, 1, 3'd7, NONE, 2'b00, 16'd3);
    step(1, 0, 0, 3'd7, NONE, 2'b00, 16'd3);
    step(0, 0, 0, 3'd0, NONE, 2'b00, 16'd0);
    step(1, 0, 0, 3'd0, NONE, 2'b00, 16'd0);
    // load with Run dropped in MEM, then reset mid-fetch
    ir_s = 16'h4123; dwr_s = 1; dmw_s = 0; dps_s = 2'b01;
    step(1, 1, 0, 3'd0, NONE, 2'b00, 16'd0);
    step(1, 1, 1, 3'd1, FACK, 2'b00, 16'd0);
    step(1, 1, 0, 3'd2, NONE, 2'b00, 16'd0);
    step(1, 0, 0, 3'd4, MREQ, 2'b00, 16'd0);
    step(1, 0, 1, 3'd4, MREQ, 2'b00, 16'd0);
    step(1, 0, 0, 3'd5, WRS,  2'b01, 16'd0);
    step(1, 1, 0, 3'd0, NONE, 2'b00, 16'd1);
    step(1, 1, 0, 3'd1, FREQ, 2'b00, 16'd1);
    step(0, 1, 1, 3'd0, NONE, 2'b00, 16'd0);
    step(1, 0, 0, 3'd0, NONE, 2'b00, 16'd0);
    // ack on the 15th fetch cycle wins over the timeout
    ir_s = 16'h0A5B; dwr_s = 1; dmw_s = 0; dps_s = 2'b01;
    step(1, 1, 0, 3'd0, NONE, 2'b00, 16'd0);
    for (int i = 0; i < 14; i++) step(1, 1, 0, 3'd1, FREQ, 2'b00, 16'd0);
    step(1, 1, 1, 3'd1, FACK, 2'b00, 16'd0);
    step(1, 0, 0, 3'd2, NONE, 2'b00, 16'd0);
    step(1, 0, 0, 3'd3, WRS,  2'b01, 16'd0);
    step(1, 0, 0, 3'd0, NONE, 2'b00, 16'd1);

    repeat (3) @(posedge Clock);
    if (exp_q.size() != 0 || n_vec != n_pushed) begin
      n_bad++;
      $display("FAIL drain: compared %0d of %0d queued vectors", n_vec, n_pushed);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_control_sequencer.md
Name: cpu_control_sequencer

Overview:
- Multi-cycle control sequencer for the 16-bit CPU datapath.
- Steps each instruction through fetch, decode, execute, memory and writeback phases.
- Qualifies the instruction decoder's combinational strobes (register write, memory write, PC select) so each fires in exactly one phase.
- Owns the memory request/acknowledge handshake, ack-timeout detection, halt detection and the retired-instruction counter.

Parameters:
- TIMEOUT, 15: maximum cycles spent in FETCH or MEM without MemAck before entering ERR. Valid range 2..255.
- CNT_W, 16: width of the Retired counter.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Run  input  1  start/continue execution; level-sensitive.
- IR  input  16  current instruction register contents.
- Dec_WR  input  1  decoder register-write strobe.
- Dec_MemWrite  input  1  decoder memory-write strobe.
- Dec_PS  input  2  decoder PC select.
- MemAck  input  1  memory completion for the current request.
- MemReq  output  1  memory request.
- AddrSel  output  1  memory address source: 0 = PC, 1 = register A bus.
- MemWrite  output  1  qualified memory write.
- IR_L  output  1  instruction register load.
- WR  output  1  qualified register-file write.
- PS  output  2  qualified PC select; 00 = hold.
- State  output  3  current state encoding.
- Busy  output  1  high in FETCH through WB.
- Err  output  1  sticky timeout error.
- Retired  output  CNT_W  count of completed instructions.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7.
- Reset (async, Reset_n=0):
  - State=IDLE, Retired=0, Err=0, wait counter=0.
  - All strobes (MemReq, MemWrite, IR_L, WR) low; PS=00; AddrSel=0.
- Instruction class from IR[15:14]:
  - 00 = ALU
  - 01 = load
  - 10 = store
  - 11 = branch, except IR=16'hFFFF, which is HALT.
- Outputs are decoded from registered State plus the listed inputs; there are no extra output registers.
- Transitions:
  - IDLE: go to FETCH when Run=1, else stay.
  - FETCH: MemReq=1, AddrSel=0. When MemAck=1, IR_L=1 that cycle and go to DECODE. Otherwise stay.
  - DECODE: no strobes; one cycle.
    - IR=FFFF -> HALT.
    - Load or store -> MEM.
    - Otherwise -> EXEC.
  - EXEC (ALU/branch): WR=Dec_WR, PS=Dec_PS; final cycle.
  - MEM: MemReq=1, AddrSel=1, MemWrite=Dec_MemWrite for store only (forced 0 for load).
    - On MemAck with store: PS=Dec_PS; final cycle.
    - On MemAck with load: go to WB.
  - WB: WR=Dec_WR, PS=Dec_PS; final cycle.
  - HALT: no strobes, Busy=0. Go to IDLE when Run=0.
  - ERR: Err=1, all strobes 0. Exits only via reset.
- Final-cycle rules:
  - Retired increments by 1 and wraps modulo 2^CNT_W.
  - Next state is FETCH if Run=1, else IDLE.
  - Run falling mid-instruction never aborts; the current instruction completes first.
- Timeout:
  - Wait counter clears on every entry to FETCH or MEM and increments each cycle MemAck=0 in those states.
  - If MemAck=0 while the counter equals TIMEOUT-1, go to ERR next edge (TIMEOUT cycles without ack in total).
  - MemAck on that same cycle takes priority over the timeout.
- MemAck is ignored outside FETCH and MEM.
- Reset asserted mid-instruction returns to IDLE immediately; no strobe may glitch high during reset.
- At most one of IR_L, WR, MemWrite is high in any cycle.

Test Plan:
- Reset, Run=1, IR=16'h0A5B (ALU), Dec_WR=1, Dec_PS=01, MemAck on the 2nd FETCH cycle:
  - State sequence 1,1,2,3,1.
  - IR_L high exactly one cycle; WR and PS=01 high only in EXEC.
  - Retired=1.
- Load IR=16'h4123, MemAck delayed 3 cycles in MEM:
  - MemReq and AddrSel=1 for 4 cycles, MemWrite=0.
  - WB cycle has WR=1; Retired increments once.
- Store IR=16'h8123, Dec_MemWrite=1, immediate ack:
  - MemWrite=1 for exactly one MEM cycle, PS=Dec_PS in that cycle, WR never high.
- TIMEOUT=15, MemAck held 0 in FETCH:
  - State=7 and Err=1 after the 15th FETCH cycle.
  - Err stays 1 while Run toggles; cleared only by Reset_n=0.
- IR=16'hFFFF:
  - FETCH->DECODE->HALT, Busy=0, Retired unchanged.
  - Run=0 -> IDLE; Run=1 -> FETCH.
- Run dropped during MEM of a load, then Reset_n pulsed low mid-FETCH of a second run:
  - Load completes through WB, then IDLE.
  - Reset forces State=0, Retired=0 asynchronously, with no strobe pulse.
